axi_mem_responder: RTL
======================

Name: axi_mem_responder

Overview:
AXI4 memory-mapped responder (subordinate) backed by an internal word-addressed RAM. It is the far end of the DMA controller's M_AXI read and write channels and serves as the synthesizable memory target for system-level DMA bring-up. Read and write paths are independent FSMs, each holding one outstanding burst, and the block supports FIXED, INCR and WRAP bursts.

Parameters:
ADDR_WD, 32, address width; must be a multiple of 8.
DATA_WD, 32, data width; must be a power of 2 and at least 8.
MEM_DEPTH, 1024, RAM depth in DATA_WD words; must be a power of 2.
STRB_WD, DATA_WD/8, localparam, number of byte lanes.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
S_AXI_ARVALID/ARREADY  in/out  1  read address handshake
S_AXI_ARADDR  in  ADDR_WD  read start address
S_AXI_ARLEN  in  8  read beats minus 1
S_AXI_ARSIZE  in  3  log2 of bytes per read beat
S_AXI_ARBURST  in  2  read burst type: 0 FIXED, 1 INCR, 2 WRAP
S_AXI_RVALID  out  1  read data valid
S_AXI_RDATA  out  DATA_WD  read data
S_AXI_RRESP  out  2  read response: 0 OKAY, 2 SLVERR
S_AXI_RLAST  out  1  last read beat
S_AXI_RREADY  in  1  read data accept
S_AXI_AWVALID/AWREADY  in/out  1  write address handshake
S_AXI_AWADDR, AWLEN, AWSIZE, AWBURST  in  ADDR_WD/8/3/2  write burst fields, same encoding as AR
S_AXI_WVALID/WREADY  in/out  1  write data handshake
S_AXI_WDATA  in  DATA_WD  write data
S_AXI_WSTRB  in  STRB_WD  byte enables
S_AXI_WLAST  in  1  last write beat
S_AXI_BVALID  out  1  write response valid
S_AXI_BRESP  out  2  write response: 0 OKAY, 2 SLVERR
S_AXI_BREADY  in  1  write response accept

Behaviour:
- Reset (rst_n low, async assert, sync deassert): read FSM to R_IDLE, write FSM to W_IDLE. ARREADY=AWREADY=1. RVALID, RLAST, WREADY and BVALID are 0. RRESP=BRESP=0. RDATA=0. RAM contents are not reset. Reset mid-burst abandons the burst with no response.
- Word index: addr[log2(STRB_WD) +: log2(MEM_DEPTH)]. Upper address bits are ignored, so the RAM aliases.
- Beat address update:
  - FIXED: address is held.
  - INCR: addr += 2^size.
  - WRAP: addr = (addr & ~(W-1)) | ((addr + 2^size) & (W-1)), with W = (len+1)*2^size.
- Illegal request (sets SLVERR):
  - size > log2(STRB_WD), or
  - WRAP with len not in {1,3,7,15}, or
  - burst type 3.
- Read FSM:
  - R_IDLE: ARREADY=1. On AR handshake, latch the fields and go to R_DATA. RVALID rises the next cycle with RDATA = RAM[start word].
  - R_DATA: ARREADY=0. The RVALID/RDATA/RLAST/RRESP outputs are registered and stay stable until RREADY.
  - On each R handshake, advance the address and the beat counter. RLAST=1 exactly when the beat counter equals len.
  - On the RLAST handshake, return to R_IDLE. The next AR can be accepted the following cycle, so the minimum cycle is len+2 per burst.
  - Illegal read: all len+1 beats are returned with RRESP=SLVERR and RDATA=0.
  - Read data returns the full word regardless of size; the master selects lanes.
- Write FSM:
  - W_IDLE: AWREADY=1. On AW handshake, latch the fields and go to W_DATA.
  - W_DATA: WREADY=1. On each W handshake, write the bytes enabled by WSTRB to RAM[word] unless the burst is illegal, then advance.
  - The burst ends on the beat where counter==len, regardless of WLAST. Then go to W_RESP.
  - Any WLAST value mismatching counter==len sets a sticky error flag.
  - W_RESP: BVALID=1, BRESP = SLVERR if illegal or flagged, else OKAY. Hold until BREADY, then go to W_IDLE with AWREADY=1 the next cycle.
  - W beats arriving before the AW handshake are not accepted (WREADY=0 outside W_DATA).
- Simultaneous read and write to the same word in the same cycle: RAM is read-first, so the read returns the old data.
- AR and AW handshakes in the same cycle are both accepted; the two paths never block each other.
- Beat counters are 8-bit. len=255 yields 256 beats with no wrap error.

Test Plan:
- Write then read: AW addr 0x100, INCR, len 3, size 2, data 0x11..0x44, WSTRB 0xF. Expect BRESP OKAY. Then AR with the same fields: RDATA 0x11,0x22,0x33,0x44, RLAST on beat 4 only, first RVALID 1 cycle after the AR handshake.
- WRAP: write 0xA0..0xA3 INCR at 0x200. Then AR addr 0x208 WRAP len 3 size 2. Expect RDATA 0xA2,0xA3,0xA0,0xA1.
- Strobes and FIXED: write 0xFFFFFFFF to 0x40, then FIXED len 1 with data 0x000000AB WSTRB 0x1 and 0x0000CD00 WSTRB 0x2. Read back 0xFFFFCDAB.
- Errors:
  - AW size 3 on a 32-bit bus, len 1: memory unchanged, BRESP=2.
  - AR WRAP len 2: 3 beats with RRESP=2 and RDATA=0.
  - WLAST asserted on beat 1 of len 2: 3 beats consumed, BRESP=2.
- Backpressure and concurrency: RREADY toggles 1/0 every cycle during a len 7 read while a len 7 write runs concurrently. RDATA is held stable while RREADY=0; all 8 beats are correct and the write completes OKAY.
- Reset mid-burst: drop rst_n during beat 2 of a len 7 read. RVALID=0 and ARREADY=1 immediately. A new AR after release completes normally.

Source files
------------

// File: rtl/axi_mem_responder.sv
// AXI4 memory responder: a word-addressed RAM served by independent read and write
// burst engines, each holding one outstanding FIXED/INCR/WRAP burst.
module axi_mem_responder #(
    parameter  int ADDR_WD   = 32,
    parameter  int DATA_WD   = 32,
    parameter  int MEM_DEPTH = 1024,
    localparam int STRB_WD   = DATA_WD / 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               S_AXI_ARVALID,
    output logic               S_AXI_ARREADY,
    input  logic [ADDR_WD-1:0] S_AXI_ARADDR,
    input  logic [7:0]         S_AXI_ARLEN,
    input  logic [2:0]         S_AXI_ARSIZE,
    input  logic [1:0]         S_AXI_ARBURST,
    output logic               S_AXI_RVALID,
    output logic [DATA_WD-1:0] S_AXI_RDATA,
    output logic [1:0]         S_AXI_RRESP,
    output logic               S_AXI_RLAST,
    input  logic               S_AXI_RREADY,
    input  logic               S_AXI_AWVALID,
    output logic               S_AXI_AWREADY,
    input  logic [ADDR_WD-1:0] S_AXI_AWADDR,
    input  logic [7:0]         S_AXI_AWLEN,
    input  logic [2:0]         S_AXI_AWSIZE,
    input  logic [1:0]         S_AXI_AWBURST,
    input  logic               S_AXI_WVALID,
    output logic               S_AXI_WREADY,
    input  logic [DATA_WD-1:0] S_AXI_WDATA,
    input  logic [STRB_WD-1:0] S_AXI_WSTRB,
    input  logic               S_AXI_WLAST,
    output logic               S_AXI_BVALID,
    output logic [1:0]         S_AXI_BRESP,
    input  logic               S_AXI_BREADY
);

    localparam int LG_STRB  = $clog2(STRB_WD);
    localparam int LG_DEPTH = $clog2(MEM_DEPTH);

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;
    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    logic [DATA_WD-1:0] r_mem [MEM_DEPTH];

    function automatic logic [ADDR_WD-1:0] next_addr(
        input logic [ADDR_WD-1:0] a,
        input logic [7:0]         len,
        input logic [2:0]         size,
        input logic [1:0]         burst
    );
        logic [ADDR_WD-1:0] inc;
        logic [ADDR_WD-1:0] mask;
        inc  = ADDR_WD'(1) << size;
        mask = ((ADDR_WD'(len) + ADDR_WD'(1)) << size) - ADDR_WD'(1);
        case (burst)
            BURST_FIXED: return a;
            BURST_WRAP:  return (a & ~mask) | ((a + inc) & mask);
            default:     return a + inc;
        endcase
    endfunction

    function automatic logic is_illegal(
        input logic [7:0] len,
        input logic [2:0] size,
        input logic [1:0] burst
    );
        logic bad_wrap;
        bad_wrap = (burst == BURST_WRAP) &&
                   !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15));
        return (size > 3'(LG_STRB)) || bad_wrap || (burst == 2'd3);
    endfunction

    // ---------------- read path ----------------
    logic [0:0]          r_rstate;
    logic [ADDR_WD-1:0]  r_raddr;
    logic [7:0]          r_rlen;
    logic [7:0]          r_rcnt;
    logic [2:0]          r_rsize;
    logic [1:0]          r_rburst;
    logic                r_rerr;
    logic                w_ar_hs;
    logic                w_r_hs;
    logic                w_ar_illegal;
    logic [ADDR_WD-1:0]  w_rnext;
    logic [ADDR_WD-1:0]  w_rd_addr;
    logic [LG_DEPTH-1:0] w_rd_word;

    assign w_ar_hs      = S_AXI_ARVALID && S_AXI_ARREADY;
    assign w_r_hs       = S_AXI_RVALID && S_AXI_RREADY;
    assign w_ar_illegal = is_illegal(S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST);
    assign w_rnext      = next_addr(r_raddr, r_rlen, r_rsize, r_rburst);
    // One RAM read port: start word when idle, following beat's word during a burst.
    assign w_rd_addr    = (r_rstate == R_IDLE) ? S_AXI_ARADDR : w_rnext;
    assign w_rd_word    = LG_DEPTH'(w_rd_addr >> LG_STRB);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rstate      <= R_IDLE;
            r_raddr       <= '0;
            r_rlen        <= '0;
            r_rcnt        <= '0;
            r_rsize       <= '0;
            r_rburst      <= '0;
            r_rerr        <= 1'b0;
            S_AXI_ARREADY <= 1'b1;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RLAST   <= 1'b0;
            S_AXI_RRESP   <= RESP_OKAY;
            S_AXI_RDATA   <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_raddr       <= S_AXI_ARADDR;
                        r_rlen        <= S_AXI_ARLEN;
                        r_rsize       <= S_AXI_ARSIZE;
                        r_rburst      <= S_AXI_ARBURST;
                        r_rerr        <= w_ar_illegal;
                        r_rcnt        <= '0;
                        S_AXI_ARREADY <= 1'b0;
                        S_AXI_RVALID  <= 1'b1;
                        S_AXI_RLAST   <= (S_AXI_ARLEN == 8'd0);
                        S_AXI_RRESP   <= w_ar_illegal ? RESP_SLVERR : RESP_OKAY;
                        S_AXI_RDATA   <= w_ar_illegal ? '0 : r_mem[w_rd_word];
                        r_rstate      <= R_DATA;
                    end
                end
                default: begin
                    if (w_r_hs) begin
                        if (S_AXI_RLAST) begin
                            S_AXI_RVALID  <= 1'b0;
                            S_AXI_RLAST   <= 1'b0;
                            S_AXI_ARREADY <= 1'b1;
                            r_rstate      <= R_IDLE;
                        end else begin
                            r_raddr     <= w_rnext;
                            r_rcnt      <= r_rcnt + 8'd1;
                            S_AXI_RLAST <= ((r_rcnt + 8'd1) == r_rlen);
                            S_AXI_RDATA <= r_rerr ? '0 : r_mem[w_rd_word];
                        end
                    end
                end
            endcase
        end
    end

    // ---------------- write path ----------------
    logic [1:0]          r_wstate;
    logic [ADDR_WD-1:0]  r_waddr;
    logic [7:0]          r_wlen;
    logic [7:0]          r_wcnt;
    logic [2:0]          r_wsize;
    logic [1:0]          r_wburst;
    logic                r_werr;
    logic                r_wflag;
    logic                w_aw_hs;
    logic                w_w_hs;
    logic                w_wlast_exp;
    logic                w_mem_we;
    logic [ADDR_WD-1:0]  w_wnext;
    logic [LG_DEPTH-1:0] w_wr_word;

    assign w_aw_hs     = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_w_hs      = S_AXI_WVALID && S_AXI_WREADY;
    assign w_wlast_exp = (r_wcnt == r_wlen);
    assign w_wnext     = next_addr(r_waddr, r_wlen, r_wsize, r_wburst);
    assign w_wr_word   = LG_DEPTH'(r_waddr >> LG_STRB);
    assign w_mem_we    = w_w_hs && !r_werr;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int unsigned i = 0; i < STRB_WD; i++) begin
                if (S_AXI_WSTRB[i]) r_mem[w_wr_word][8*i +: 8] <= S_AXI_WDATA[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wstate      <= W_IDLE;
            r_waddr       <= '0;
            r_wlen        <= '0;
            r_wcnt        <= '0;
            r_wsize       <= '0;
            r_wburst      <= '0;
            r_werr        <= 1'b0;
            r_wflag       <= 1'b0;
            S_AXI_AWREADY <= 1'b1;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= RESP_OKAY;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (w_aw_hs) begin
                        r_waddr       <= S_AXI_AWADDR;
                        r_wlen        <= S_AXI_AWLEN;
                        r_wsize       <= S_AXI_AWSIZE;
                        r_wburst      <= S_AXI_AWBURST;
                        r_werr        <= is_illegal(S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST);
                        r_wflag       <= 1'b0;
                        r_wcnt        <= '0;
                        S_AXI_AWREADY <= 1'b0;
                        S_AXI_WREADY  <= 1'b1;
                        r_wstate      <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_w_hs) begin
                        // The beat count, not WLAST, closes the burst; a WLAST mismatch only taints BRESP.
                        if (w_wlast_exp) begin
                            S_AXI_WREADY <= 1'b0;
                            S_AXI_BVALID <= 1'b1;
                            S_AXI_BRESP  <= (r_werr || r_wflag || !S_AXI_WLAST) ? RESP_SLVERR : RESP_OKAY;
                            r_wstate     <= W_RESP;
                        end else begin
                            r_waddr <= w_wnext;
                            r_wcnt  <= r_wcnt + 8'd1;
                            if (S_AXI_WLAST) r_wflag <= 1'b1;
                        end
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        S_AXI_BVALID  <= 1'b0;
                        S_AXI_BRESP   <= RESP_OKAY;
                        S_AXI_AWREADY <= 1'b1;
                        r_wstate      <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

endmodule
